// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw, asynchronous, bouncy push-button or switch input into a clean
// registered level. It also produces single-cycle rise and fall strobes for
// downstream sequential logic. The debounced level y feeds not_gate.a.
//
// The raw input passes through a two-flop synchronizer (a -> s1 -> s2). A
// four-state FSM then only accepts a new level after STABLE_CYCLES
// consecutive synchronized samples of that level.
//
// Ports
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous, active-high reset (clears every register)
//   a     in   1  raw asynchronous input
//   y     out  1  debounced level (registered)
//   rise  out  1  one-cycle pulse in the first cycle y reads 1
//   fall  out  1  one-cycle pulse in the first cycle y reads 0
//   y_n   out  1  ~y, only when DEBOUNCE_INV_EN is defined
//
// Build option
//   DEBOUNCE_INV_EN : when defined, adds y_n = ~y, taken straight from the
//                     y register. y_n is 1 during reset. When it is not
//                     defined, the port is absent and a separate not_gate
//                     does the inversion.
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   output logic y,
   output logic rise,
   output logic fall
`ifdef DEBOUNCE_INV_EN
   ,
   output logic y_n
`endif
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   // The sample taken on the current edge completes the run once cnt reaches
   // LAST. The first sample is counted on entry to the wait state, so y moves
   // STABLE_CYCLES+2 edges after a first samples the new level. When
   // STABLE_CYCLES=1, the wait state is still visited for a single edge.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE_LOW,
      WAIT_HIGH,
      IDLE_HIGH,
      WAIT_LOW
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             s1;
   logic             s2;
   logic             run_done;

   assign run_done = (cnt >= LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= IDLE_LOW;
         cnt   <= '0;
         y     <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1   <= a;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            IDLE_LOW: begin
               if (s2) begin
                  state <= WAIT_HIGH;
                  cnt   <= ONE;
               end else begin
                  cnt <= '0;
               end
            end
            WAIT_HIGH: begin
               // Any return to the current level aborts, even on the final edge.
               if (!s2) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
               end else if (run_done) begin
                  state <= IDLE_HIGH;
                  y     <= 1'b1;
                  rise  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            IDLE_HIGH: begin
               if (!s2) begin
                  state <= WAIT_LOW;
                  cnt   <= ONE;
               end else begin
                  cnt <= '0;
               end
            end
            WAIT_LOW: begin
               if (s2) begin
                  state <= IDLE_HIGH;
                  cnt   <= '0;
               end else if (run_done) begin
                  state <= IDLE_LOW;
                  y     <= 1'b0;
                  fall  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef DEBOUNCE_INV_EN
   assign y_n = ~y;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed scenarios followed by a randomized phase, all checked every cycle
// against a run-length reference model. The model sees a two edges late and
// flips its level after N consecutive differing samples. Build with
// +define+DEBOUNCE_INV_EN to also cover y_n.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a   = 1'b0;
   logic y, rise, fall;
`ifdef DEBOUNCE_INV_EN
   logic y_n;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic m_d1 = 1'b0, m_d2 = 1'b0, m_y = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
   int   m_run = 0;

   // observed pulse counters, cleared per scenario
   int rise_cnt = 0;
   int fall_cnt = 0;

   always #5 clk = ~clk;

   button_debouncer #(.STABLE_CYCLES(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .y    (y),
      .rise (rise),
      .fall (fall)
`ifdef DEBOUNCE_INV_EN
      ,
      .y_n  (y_n)
`endif
   );

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock edge. Inputs change on the falling edge, the model advances
   // on the rising edge, and outputs are compared 1 time unit later.
   task automatic step(input logic a_v, input logic rst_v);
      logic seen;
      @(negedge clk);
      a   = a_v;
      rst = rst_v;
      @(posedge clk);
      if (rst_v) begin
         m_d1 = 1'b0; m_d2 = 1'b0; m_y = 1'b0; m_run = 0;
         m_rise = 1'b0; m_fall = 1'b0;
      end else begin
         seen   = m_d2;
         m_d2   = m_d1;
         m_d1   = a_v;
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (seen != m_y) begin
            m_run++;
            if (m_run >= N) begin
               m_y    = seen;
               m_rise = seen;
               m_fall = ~seen;
               m_run  = 0;
            end
         end else begin
            m_run = 0;
         end
      end
      #1;
      check_bit("y", y, m_y);
      check_bit("rise", rise, m_rise);
      check_bit("fall", fall, m_fall);
      check_bit("rise_fall_exclusive", rise & fall, 1'b0);
`ifdef DEBOUNCE_INV_EN
      check_bit("y_n", y_n, ~m_y);
`endif
      if (rise === 1'b1) rise_cnt++;
      if (fall === 1'b1) fall_cnt++;
   endtask

   // Holds a at a_v. Returns the edge number (1-based) on which y first
   // reads a_v, or -1 if that does not happen within max_edges.
   task automatic hold(input logic a_v, input int max_edges, output int lat);
      lat = -1;
      for (int i = 1; i <= max_edges; i++) begin
         step(a_v, 1'b0);
         if (lat < 0 && y === a_v) lat = i;
      end
   endtask

   initial begin
      int lat;

      // 1: reset with a=1, then release with a held high
      step(1'b1, 1'b1);
      check_bit("t1_reset_y", y, 1'b0);
      step(1'b1, 1'b1);
      check_bit("t1_reset_rise", rise, 1'b0);
      check_bit("t1_reset_fall", fall, 1'b0);
      rise_cnt = 0;
      hold(1'b1, 10, lat);
      check_int("t1_latency", lat, N + 2);
      check_int("t1_rise_count", rise_cnt, 1);

      // return to low
      fall_cnt = 0;
      hold(1'b0, 10, lat);
      check_int("return_low_latency", lat, N + 2);
      check_int("return_low_fall_count", fall_cnt, 1);

      // 2: short high pulse of 3 edges is rejected
      rise_cnt = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      check_bit("t2_y_low", y, 1'b0);
      check_int("t2_rise_count", rise_cnt, 0);

      // 3: bounce for 10 edges, then held high
      rise_cnt = 0;
      for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      hold(1'b1, 10, lat);
      check_int("t3_latency", lat, N + 2);
      check_int("t3_rise_count", rise_cnt, 1);

      // 4: 3 low samples, 1 high sample, then held low
      fall_cnt = 0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check_bit("t4_y_still_high", y, 1'b1);
      hold(1'b0, 10, lat);
      check_int("t4_latency", lat, N + 2);
      check_int("t4_fall_count", fall_cnt, 1);

      // 5: reset while the high count is at 3
      rise_cnt = 0;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check_bit("t5_reset_y", y, 1'b0);
      check_int("t5_no_rise_before_reset", rise_cnt, 0);
      hold(1'b1, 10, lat);
      check_int("t5_latency", lat, N + 2);
      check_int("t5_rise_count", rise_cnt, 1);

      // randomized phase: random run lengths and occasional resets
      for (int k = 0; k < 600; k++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(1, 0));
         len = $urandom_range(9, 1);
         if ($urandom_range(99, 0) < 3) step(lvl, 1'b1);
         for (int j = 0; j < len; j++) step(lvl, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
